alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALUOperation code produced by the ALU control decoder and performs the selected operation on two operands. Logic and arithmetic ops complete in one clock. Shifts run iteratively, one bit per clock, under a valid/ready input handshake. It sits between the decode/control path (op code, register operands, shamt) and the writeback/branch logic (result, zero flag).

## Interface
- WIDTH, 32: datapath width in bits; must be even and at least 4.
- SHAMT_W, 5: shift-amount width; 2**SHAMT_W == WIDTH.
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- alu_operation  input  4  op code from ALU control.
- operand_a  input  WIDTH  rs operand.
- operand_b  input  WIDTH  rt / immediate operand.
- shamt  input  SHAMT_W  shift amount.
- out_valid  output  1  one-cycle pulse; result/zero are new this cycle.
- result  output  WIDTH  registered result; held until the next out_valid.
- zero  output  1  registered, (result == 0), updated with result.
- busy  output  1  multi-cycle shift in progress (== ~in_ready).

## Operation
- Op codes:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 NOR: ~(A|B).
  - 0011 ADD: A+B mod 2^WIDTH; carry discarded, no overflow flag.
  - 0100 SUB: A-B mod 2^WIDTH; used for BEQ/BNE via zero.
  - 0101 LUI: B[WIDTH/2-1:0] placed in the upper half, lower half 0.
  - 1111 SLL: B << shamt, zero fill.
  - 1110 SRL: B >> shamt (logical), zero fill.
  - 1001 and all other codes: no-op. result = 0, zero = 1, out_valid still pulses.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. alu_operation, operand_a, operand_b and shamt are sampled only then.
- State machine, 2 states:
  - IDLE: in_ready = 1.
    - Non-shift, or shift with shamt = 0: compute, register result/zero, pulse out_valid, stay in IDLE. Back-to-back accepts every cycle are allowed.
    - Shift with shamt ≥ 1: load accumulator = B shifted by 1 bit and count = shamt-1.
      - If count = 0: register result and pulse out_valid, stay in IDLE.
      - Otherwise go to SHIFT.
  - SHIFT: in_ready = 0, busy = 1. Each edge shifts the accumulator 1 bit in the latched direction and decrements count.
    - When the shift with count = 1 completes: register result, pulse out_valid, return to IDLE.
- in_valid while busy: ignored. Inputs are not sampled and no error is raised. The requester must hold the request.
- out_valid has no back-pressure. Consumers must capture it on the pulse.

## Timing
- Reset values: state IDLE, in_ready = 1, busy = 0, out_valid = 0, result = 0, zero = 1, accumulator/count = 0.
- Reset asserted mid-shift: the in-flight op is discarded and no out_valid is produced. Outputs take their reset values asynchronously.
- Latency: accept at edge k. out_valid is high for the cycle after edge k + max(1, shamt) − 1 for shifts, and after edge k for all other ops.
- Shift with shamt = s ≥ 2: in_ready is low for s−1 cycles. The next accept is possible at edge k+s.
- Throughput: 1 op/cycle for non-shifts; 1 per max(1, s) cycles for shifts.
- The zero flag is coincident with result. result and zero do not change without out_valid.

## Test plan
- Reset: assert reset asynchronously mid-cycle. Required: in_ready = 1, out_valid = 0, result = 0, zero = 1 immediately, before any clock edge.
- Single-cycle ops, back-to-back on consecutive edges:
  - ADD A=0xFFFFFFFF, B=1 -> result 0, zero 1.
  - SUB 5-3 -> 2, zero 0.
  - NOR 0,0 -> 0xFFFFFFFF.
  - LUI B=0x00001234 -> 0x12340000.
  - Required: out_valid high on 4 consecutive cycles.
- Shifts:
  - SLL B=1, shamt=31 -> 0x80000000 after 31 edges; in_ready low for exactly 30 cycles.
  - SRL B=0x80000000, shamt=4 -> 0x08000000.
  - SLL shamt=0 -> B in 1 cycle.
  - SLL shamt=1 -> 1 cycle, in_ready never drops.
- Busy collision: during SLL shamt=8, drive ADD 1+1 with in_valid held. Required: ADD accepted at the edge where in_ready returns. Shift result is followed by result 2 one cycle later; the ADD operands are not sampled early.
- No-op / unknown codes: op 1001 and op 0110 with A=7, B=9. Required: out_valid pulses, result 0, zero 1.
- Reset mid-shift: SRL shamt=20, assert reset after 5 cycles. Required: no out_valid, result 0, in_ready 1. The next ADD 2+2 after release returns 4 with latency 1.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between decode/control and the execute-stage ALU.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         alu_operation;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               busy;

  modport master (
    output in_valid, alu_operation, operand_a, operand_b, shamt,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_operation, operand_a, operand_b, shamt,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative one-bit-per-clock
// shifts behind a valid/ready handshake; registered result and zero flag.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b1110;
  localparam logic [3:0] OP_SLL = 4'b1111;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             state;
  logic               ready_q;
  logic               busy_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] count;
  logic               dir_left;

  logic               is_sll_c;
  logic               is_shift_c;
  logic [WIDTH-1:0]   alu_c;
  logic [WIDTH-1:0]   first_c;
  logic [WIDTH-1:0]   next_c;

  assign is_sll_c   = (bus.alu_operation == OP_SLL);
  assign is_shift_c = is_sll_c || (bus.alu_operation == OP_SRL);
  assign first_c    = is_sll_c ? (bus.operand_b << 1) : (bus.operand_b >> 1);
  assign next_c     = dir_left ? (acc << 1) : (acc >> 1);

  // Single-cycle result; a shift reaching here has shamt = 0 and passes B through.
  always_comb begin
    alu_c = '0;
    case (bus.alu_operation)
      OP_AND:         alu_c = bus.operand_a & bus.operand_b;
      OP_OR:          alu_c = bus.operand_a | bus.operand_b;
      OP_NOR:         alu_c = ~(bus.operand_a | bus.operand_b);
      OP_ADD:         alu_c = bus.operand_a + bus.operand_b;
      OP_SUB:         alu_c = bus.operand_a - bus.operand_b;
      OP_LUI:         alu_c = {bus.operand_b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL, OP_SRL: alu_c = bus.operand_b;
      default:        alu_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      acc      <= '0;
      count    <= '0;
      dir_left <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (is_shift_c && (bus.shamt != '0)) begin
              // First bit of the shift happens on the accept edge.
              acc      <= first_c;
              count    <= bus.shamt - SHAMT_W'(1);
              dir_left <= is_sll_c;
              if (bus.shamt == SHAMT_W'(1)) begin
                result_q <= first_c;
                zero_q   <= (first_c == '0);
                valid_q  <= 1'b1;
              end else begin
                state   <= S_SHIFT;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end else begin
              result_q <= alu_c;
              zero_q   <= (alu_c == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          acc   <= next_c;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            result_q <= next_c;
            zero_q   <= (next_c == '0);
            valid_q  <= 1'b1;
            state    <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: vector table for single-cycle
// ops plus hand sequences for shifts, busy collision and reset.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [31:0] r, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.shamt = sh; v.exp_result = r; v.exp_zero = z;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bus.in_valid      = v;
    bus.alu_operation = op;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.shamt         = sh;
  endtask

  // Accept a shift, then count edges until out_valid and in_ready-low samples.
  task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] exp);
    int n;
    int low;
    drive(1'b1, op, 32'h0, b, sh);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n = 1;
    low = 0;
    while (!bus.out_valid && n < 64) begin
      if (!bus.in_ready) low++;
      tick();
      n++;
    end
    check({name, " result"}, bus.result, exp);
    check({name, " edges"}, 32'(n), 32'(sh));
    check({name, " ready_low"}, 32'(low), 32'(sh) - 32'd1);
    check({name, " ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    clk    = 1'b0;
    reset  = 1'b1;
    errors = 0;
    checks = 0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);

    vecs[0]  = mk(4'b0011, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0,         1'b1); // ADD wrap
    vecs[1]  = mk(4'b0100, 32'd5,         32'd3,         5'd0, 32'd2,         1'b0); // SUB
    vecs[2]  = mk(4'b0010, 32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0); // NOR
    vecs[3]  = mk(4'b0101, 32'h0,         32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0); // LUI
    vecs[4]  = mk(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0); // AND
    vecs[5]  = mk(4'b0001, 32'h0000_000F, 32'h0000_00F0, 5'd0, 32'h0000_00FF, 1'b0); // OR
    vecs[6]  = mk(4'b1111, 32'h0,         32'h0000_ABCD, 5'd0, 32'h0000_ABCD, 1'b0); // SLL 0
    vecs[7]  = mk(4'b1110, 32'h0,         32'h8000_0001, 5'd0, 32'h8000_0001, 1'b0); // SRL 0
    vecs[8]  = mk(4'b1111, 32'h0,         32'h8000_0003, 5'd1, 32'h0000_0006, 1'b0); // SLL 1
    vecs[9]  = mk(4'b1110, 32'h0,         32'h0000_0006, 5'd1, 32'h0000_0003, 1'b0); // SRL 1
    vecs[10] = mk(4'b1001, 32'd7,         32'd9,         5'd0, 32'h0,         1'b1); // no-op
    vecs[11] = mk(4'b0110, 32'd7,         32'd9,         5'd0, 32'h0,         1'b1); // unknown

    // Release reset, load a nonzero result, then reset asynchronously mid-cycle.
    tick(); tick();
    reset = 1'b0;
    drive(1'b1, 4'b0011, 32'd2, 32'd3, 5'd0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    check("pre_reset result", bus.result, 32'd5);
    #2 reset = 1'b1;
    #1;
    check("async_rst in_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst result", bus.result, 32'h0);
    check("async_rst zero", 32'(bus.zero), 32'd1);
    check("async_rst busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b0;

    // Single-cycle vectors back to back on consecutive edges.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d result", i), bus.result, vecs[i].exp_result);
      check($sformatf("vec%0d zero", i), 32'(bus.zero), 32'(vecs[i].exp_zero));
      check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    tick();
    check("idle out_valid", 32'(bus.out_valid), 32'd0);
    check("idle hold result", bus.result, 32'h0);

    // Multi-cycle shifts.
    run_shift("sll31", 4'b1111, 32'h1, 5'd31, 32'h8000_0000);
    tick();
    run_shift("srl4", 4'b1110, 32'h8000_0000, 5'd4, 32'h0800_0000);
    tick();
    check("shift hold result", bus.result, 32'h0800_0000);
    check("shift hold valid", 32'(bus.out_valid), 32'd0);

    // Busy collision: ADD held during SLL shamt=8.
    drive(1'b1, 4'b1111, 32'h0, 32'h1, 5'd8);
    tick();
    drive(1'b1, 4'b0011, 32'd1, 32'd1, 5'd0);
    n = 1;
    while (!bus.out_valid && n < 64) begin
      check("coll busy", 32'(bus.busy), 32'd1);
      tick();
      n++;
    end
    check("coll shift result", bus.result, 32'h0000_0100);
    check("coll shift edges", 32'(n), 32'd8);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    check("coll add valid", 32'(bus.out_valid), 32'd1);
    check("coll add result", bus.result, 32'd2);
    check("coll add zero", 32'(bus.zero), 32'd0);
    tick();
    check("coll after valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-shift discards the op.
    drive(1'b1, 4'b1110, 32'h0, 32'hFFFF_FFFF, 5'd20);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      check("midshift no valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst result", bus.result, 32'h0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    tick(); tick();
    reset = 1'b0;
    drive(1'b1, 4'b0011, 32'd2, 32'd2, 5'd0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    check("post_rst add valid", 32'(bus.out_valid), 32'd1);
    check("post_rst add result", bus.result, 32'd4);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_rst quiet", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst hold", bus.result, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
